// File: rtl/output_pkg.sv
// Lane constants and packer state shared with the output fetch stage so that
// pack and unpack byte ordering stay identical.
package output_pkg;

  localparam int unsigned BYTES_PER_WORD = 16;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 128;
  localparam logic [3:0]  LAST_LANE      = 4'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2
  } packer_state_t;

  // Lane i occupies bits [127-8i -: 8]; lane 0 is the most significant byte.
  function automatic logic [WORD_W-1:0] insert_byte(
    input logic [WORD_W-1:0] word,
    input logic [3:0]        idx,
    input logic [BYTE_W-1:0] data_byte
  );
    logic [WORD_W-1:0] w_word;
    w_word = word;
    w_word[WORD_W - 1 - BYTE_W * idx -: BYTE_W] = data_byte;
    return w_word;
  endfunction

endpackage

// File: rtl/output_packer.sv
// Reassembles the fetch stage's byte stream into 128-bit MSB-first words and
// writes them to output memory; flushes a zero-padded partial word at stream end.
module output_packer
  import output_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        DataIn,
  output logic [127:0]      WriteBus,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic              WriteEnable,
  output logic              Done,
  output logic [ADDR_W-1:0] WordCount
);

  packer_state_t     r_state, w_state;
  logic [3:0]        r_idx, w_idx;
  logic [127:0]      r_asm, w_asm;
  logic [ADDR_W-1:0] r_wptr, w_wptr;
  logic [127:0]      r_wbus, w_wbus;
  logic [ADDR_W-1:0] r_waddr, w_waddr;
  logic              r_we, w_we;
  logic              r_done, w_done;
  logic [ADDR_W-1:0] r_wcount, w_wcount;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state;
  end

  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_asm    = r_asm;
    w_wptr   = r_wptr;
    w_wbus   = r_wbus;
    w_waddr  = r_waddr;
    w_we     = 1'b0;
    w_done   = 1'b0;
    w_wcount = r_wcount;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_asm    = insert_byte('0, 4'd0, DataIn);
          w_idx    = 4'd1;
          w_wcount = '0;
          w_state  = PACK;
        end
      end
      PACK: begin
        if (start) begin
          if (r_idx == LAST_LANE) begin
            w_wbus   = insert_byte(r_asm, r_idx, DataIn);
            w_waddr  = r_wptr;
            w_we     = 1'b1;
            w_wptr   = r_wptr + ADDR_W'(1);
            w_wcount = r_wcount + ADDR_W'(1);
            w_idx    = '0;
            w_asm    = '0;
          end else begin
            w_asm = insert_byte(r_asm, r_idx, DataIn);
            w_idx = r_idx + 4'd1;
          end
        end else begin
          // Unfilled lanes are already zero because asm is cleared per word.
          if (r_idx != 4'd0) begin
            w_wbus   = r_asm;
            w_waddr  = r_wptr;
            w_we     = 1'b1;
            w_wcount = r_wcount + ADDR_W'(1);
          end
          w_idx   = '0;
          w_asm   = '0;
          w_state = FLUSH;
        end
      end
      FLUSH: begin
        w_done = 1'b1;
        w_wptr = '0;
        w_idx  = '0;
        if (start) begin
          w_asm    = insert_byte('0, 4'd0, DataIn);
          w_idx    = 4'd1;
          w_wcount = '0;
          w_state  = PACK;
        end else begin
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx    <= '0;
      r_asm    <= '0;
      r_wptr   <= '0;
      r_wbus   <= '0;
      r_waddr  <= '0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_wcount <= '0;
    end else begin
      r_idx    <= w_idx;
      r_asm    <= w_asm;
      r_wptr   <= w_wptr;
      r_wbus   <= w_wbus;
      r_waddr  <= w_waddr;
      r_we     <= w_we;
      r_done   <= w_done;
      r_wcount <= w_wcount;
    end
  end

  assign WriteBus     = r_wbus;
  assign WriteAddress = r_waddr;
  assign WriteEnable  = r_we;
  assign Done         = r_done;
  assign WordCount    = r_wcount;

endmodule
